// File: rtl/wb_regfile_pkg.sv
// Shared writeback/register-file constants and the ResultSrc encoding.
package wb_regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREG);

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_NONE = 2'b11
    } result_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback and decode-read signal bundle of the register file.
interface wb_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned IDX_W = $clog2(NREG);

    logic             RegWriteW;
    logic [1:0]       ResultSrcW;
    logic [XLEN-1:0]  ALUResultW;
    logic [XLEN-1:0]  ReadDataW;
    logic [IDX_W-1:0] RdW;
    logic [XLEN-1:0]  PCPlus4W;
    logic [IDX_W-1:0] Rs1D;
    logic [IDX_W-1:0] Rs2D;
    logic [XLEN-1:0]  RD1D;
    logic [XLEN-1:0]  RD2D;
    logic [XLEN-1:0]  ResultW;
    logic [31:0]      WrCount;

    modport master (
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, WrCount
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, WrCount
    );

endinterface

// File: rtl/wb_result_mux.sv
// Writeback result select; the reserved encoding drives zero.
module wb_result_mux
    import wb_regfile_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] pc4_i,
    output logic [W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (result_src_e'(sel_i))
            RES_ALU:  result_o = alu_i;
            RES_MEM:  result_o = mem_i;
            RES_PC4:  result_o = pc4_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback result mux and commit counter.
// Define WB_REGFILE_BYPASS_EN to forward a pending commit to same-cycle reads.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [31:0]     wr_count_q;
    logic [31:0]     wr_count_d;
    logic [XLEN-1:0] result;
    logic            commit;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    wb_result_mux #(.W(XLEN)) u_mux (
        .sel_i    (bus.ResultSrcW),
        .alu_i    (bus.ALUResultW),
        .mem_i    (bus.ReadDataW),
        .pc4_i    (bus.PCPlus4W),
        .result_o (result)
    );

    // x0 and the reserved select never commit; reset wins over any write.
    always_comb begin
        commit     = bus.RegWriteW && (bus.RdW != '0) &&
                     (bus.ResultSrcW != RES_NONE) && !reset;
        wr_count_d = wr_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (commit) begin
            regs_q[bus.RdW] <= result;
            wr_count_q      <= wr_count_d;
        end
    end

    always_comb begin
        rd1 = (bus.Rs1D == '0) ? '0 : regs_q[bus.Rs1D];
        rd2 = (bus.Rs2D == '0) ? '0 : regs_q[bus.Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
        // Write-through: commit already excludes x0.
        if (commit && (bus.RdW == bus.Rs1D)) rd1 = result;
        if (commit && (bus.RdW == bus.Rs2D)) rd2 = result;
`endif
    end

    assign bus.RD1D    = rd1;
    assign bus.RD2D    = rd2;
    assign bus.ResultW = result;
    assign bus.WrCount = wr_count_q;

    logic unused_idx;
    assign unused_idx = ^IDX_W;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus random checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;

    logic clk;
    logic reset;

    wb_regfile_if #(.XLEN(32), .NREG(32)) bus ();

    wb_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    int unsigned errors;
    int unsigned checks;

    function automatic logic [31:0] m_result();
        case (bus.ResultSrcW)
            2'd0:    return bus.ALUResultW;
            2'd1:    return bus.ReadDataW;
            2'd2:    return bus.PCPlus4W;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_commit();
        return bus.RegWriteW && bus.RdW != 5'd0 && bus.ResultSrcW != 2'd3 && !reset;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (BYPASS && m_commit() && bus.RdW == idx) return m_result();
        return m_regs[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, let them settle.
    task automatic drive(input logic rst, input logic we, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        reset          = rst;
        bus.RegWriteW  = we;
        bus.ResultSrcW = sel;
        bus.ALUResultW = alu;
        bus.ReadDataW  = mem;
        bus.PCPlus4W   = pc4;
        bus.RdW        = rd;
        bus.Rs1D       = rs1;
        bus.Rs2D       = rs2;
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ResultW"}, bus.ResultW, m_result());
        chk({tag, ".RD1D"},    bus.RD1D,    m_read(bus.Rs1D));
        chk({tag, ".RD2D"},    bus.RD2D,    m_read(bus.Rs2D));
        chk({tag, ".WrCount"}, bus.WrCount, m_cnt);
    endtask

    // Advance one rising edge and update the model from the inputs presented.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (m_commit()) begin
            m_regs[bus.RdW] = m_result();
            m_cnt           = m_cnt + 32'd1;
        end
    endtask

    task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, rs1, rs2);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_cnt  = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Reset
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
        tick();
        idle_read(5'd5, 5'd31);
        chk("reset.WrCount", bus.WrCount, 32'd0);
        chk("reset.RD1D",    bus.RD1D,    32'd0);
        chk("reset.RD2D",    bus.RD2D,    32'd0);

        // Write x5
        drive(1'b0, 1'b1, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 5'd5, 5'd1, 5'd2);
        check_all("w5");
        tick();
        idle_read(5'd5, 5'd5);
        chk("x5.RD1D",    bus.RD1D,    32'h1234_5678);
        chk("x5.RD2D",    bus.RD2D,    32'h1234_5678);
        chk("x5.WrCount", bus.WrCount, 32'd1);

        // Write to x0 is discarded
        drive(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        chk("x0w.RD1D", bus.RD1D, 32'd0);
        tick();
        idle_read(5'd0, 5'd0);
        chk("x0.RD1D",    bus.RD1D,    32'd0);
        chk("x0.RD2D",    bus.RD2D,    32'd0);
        chk("x0.WrCount", bus.WrCount, 32'd1);

        // Same-cycle hazard on x7
        drive(1'b0, 1'b1, 2'd0, 32'hA, 32'd0, 32'd0, 5'd7, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 2'd1, 32'd0, 32'hB, 32'd0, 5'd7, 5'd0, 5'd7);
        chk("haz.RD2D", bus.RD2D, BYPASS ? 32'hB : 32'hA);
        tick();
        idle_read(5'd0, 5'd7);
        chk("haz.next.RD2D", bus.RD2D, 32'hB);
        chk("haz.WrCount",   bus.WrCount, 32'd3);

        // Link write and reserved select
        drive(1'b0, 1'b1, 2'd2, 32'h1, 32'h2, 32'h104, 5'd1, 5'd0, 5'd0);
        check_all("link");
        tick();
        idle_read(5'd1, 5'd0);
        chk("link.x1", bus.RD1D, 32'h104);
        drive(1'b0, 1'b1, 2'd3, 32'h999, 32'h888, 32'h777, 5'd2, 5'd2, 5'd0);
        chk("rsvd.ResultW", bus.ResultW, 32'd0);
        chk("rsvd.RD1D",    bus.RD1D,    32'd0);
        tick();
        idle_read(5'd2, 5'd1);
        chk("rsvd.x2",      bus.RD1D,    32'd0);
        chk("rsvd.WrCount", bus.WrCount, 32'd4);

        // Reset mid-operation drops a same-cycle write; reads stay live during reset
        drive(1'b1, 1'b1, 2'd0, 32'h55, 32'd0, 32'd0, 5'd3, 5'd3, 5'd5);
        chk("rstw.RD1D", bus.RD1D, 32'd0);
        chk("rstw.RD2D", bus.RD2D, 32'h1234_5678);
        tick();
        idle_read(5'd3, 5'd5);
        chk("rstw.x3",      bus.RD1D,    32'd0);
        chk("rstw.x5",      bus.RD2D,    32'd0);
        chk("rstw.WrCount", bus.WrCount, 32'd0);

        // Counter wrap
        @(negedge clk);
        dut.wr_count_q = 32'hFFFF_FFFF;
        m_cnt          = 32'hFFFF_FFFF;
        drive(1'b0, 1'b1, 2'd0, 32'hCAFE, 32'd0, 32'd0, 5'd4, 5'd4, 5'd0);
        chk("wrap.pre", bus.WrCount, 32'hFFFF_FFFF);
        tick();
        idle_read(5'd4, 5'd0);
        chk("wrap.WrCount", bus.WrCount, 32'd0);
        chk("wrap.x4",      bus.RD1D,    32'hCAFE);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] rs1;
            logic [4:0] rs2;
            rd  = 5'($urandom_range(31));
            rs1 = ($urandom_range(2) == 0) ? rd : 5'($urandom_range(31));
            rs2 = ($urandom_range(2) == 0) ? rd : 5'($urandom_range(31));
            drive(($urandom_range(24) == 0), 1'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, rd, rs1, rs2);
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of results and registers.
REQ-002 Parameter NREG, default 32, register count; the RdW/Rs width is log2(NREG), which is 5 at default.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port RegWriteW  in  1  writeback write enable from the MEM/WB register.
REQ-006 Port ResultSrcW  in  2  result select from the MEM/WB register.
REQ-007 Port ALUResultW  in  XLEN  ALU result.
REQ-008 Port ReadDataW  in  XLEN  load data.
REQ-009 Port RdW  in  5  destination register index.
REQ-010 Port PCPlus4W  in  XLEN  link address.
REQ-011 Port Rs1D, Rs2D  in  5 each  decode-stage source indices.
REQ-012 Port RD1D, RD2D  out  XLEN each  decode-stage read data.
REQ-013 Port ResultW  out  XLEN  selected writeback result, exported to forwarding logic.
REQ-014 Port WrCount  out  32  count of committed register writes.

Function
REQ-015 ResultW is combinational: 00 selects ALUResultW, 01 selects ReadDataW, 10 selects PCPlus4W, and 11 drives 0.
REQ-016 A commit occurs when all of the following hold: RegWriteW=1, RdW!=0, ResultSrcW!=11 and reset=0.
REQ-017 On a commit, regs[RdW] takes ResultW at the rising clk edge; the latency is 1 cycle.
REQ-018 x0 always reads 0, and writes to RdW=0 are discarded without incrementing WrCount.
REQ-019 ResultSrcW=11 with RegWriteW=1 suppresses the write and does not count; it is a reserved encoding.
REQ-020 RD1D/RD2D are combinational reads of regs[Rs1D]/regs[Rs2D], subject to the bypass rule in REQ-026.
REQ-021 WrCount increments by 1 per commit and wraps from 0xFFFF_FFFF to 0.
REQ-022 When both read ports address the same register they return identical data.

Reset
REQ-023 While reset=1 at a rising edge, all registers clear to 0 and WrCount clears to 0.
REQ-024 A write presented in the same cycle as reset is dropped, and reset takes priority.
REQ-025 Read ports remain combinational during reset and return the currently stored contents.

Configuration
REQ-026 Macro WB_REGFILE_BYPASS_EN defined: when a commit to index r is pending, a read of r returns ResultW in that same cycle (write-through), except for r=0.
REQ-027 Macro WB_REGFILE_BYPASS_EN undefined: reads return only stored contents (the old value), so the hazard unit shall stall decode one cycle on a WB/D register match.

Structure
REQ-028 A shared package holds the ResultSrc encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_NONE=11), XLEN and the register-index width.
REQ-029 One sub-module, wb_result_mux, implements REQ-015; the register array, counter and bypass logic live in wb_regfile.

Verification
REQ-030 Reset, then write x5: RegWriteW=1, ResultSrcW=00, ALUResultW=0x1234_5678, RdW=5; the next cycle, Rs1D=5 shall give RD1D=0x1234_5678 and WrCount=1.
REQ-031 Write to x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFF_FFFF; then Rs1D=Rs2D=0 shall give 0 on both ports, with WrCount unchanged.
REQ-032 Same-cycle hazard: x7 holds 0xA, and a write to x7 of ReadDataW=0xB with ResultSrcW=01 is presented while Rs2D=7. With BYPASS_EN, RD2D=0xB in that cycle; without it, RD2D=0xA, then 0xB on the next cycle.
REQ-033 Link write: ResultSrcW=10, PCPlus4W=0x104, RdW=1 shall give x1=0x104. Reserved select ResultSrcW=11 with RdW=2 shall leave x2 unchanged and WrCount unchanged.
REQ-034 Reset mid-operation: a write to x3 of 0x55 in the same cycle as reset=1 shall leave x3=0 and WrCount=0 afterwards. Force WrCount to 0xFFFF_FFFF and commit once, and it shall read 0.
